// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the mode type used by the data path and bench.
package shift_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t SHL = 2'b00;
   localparam mode_t SHR = 2'b01;
   localparam mode_t ROL = 2'b10;
   localparam mode_t ROR = 2'b11;

   // Right-moving modes have mode[0] set; so taps the LSB for them.
   function automatic logic is_right(input mode_t m);
      return m[0];
   endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Saturating count of shift edges since the last clear, with a one-cycle
// done pulse on the edge that completes a full WIDTH-bit frame.
module shift_frame_cnt #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       inc,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] FULL = CW'(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_next;
   logic          done_next;

   always_comb begin
      cnt_next  = cnt;
      done_next = 1'b0;
      if (clr) begin
         cnt_next = '0;
      end else if (inc) begin
         // Saturate at FULL so done fires only once per frame.
         if (cnt != FULL) begin
            cnt_next = cnt + 1'b1;
         end
         done_next = (cnt == LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         done <= done_next;
      end
   end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, shift/rotate in both directions,
// clock enable, and a frame counter reporting completed words.
module shift_reg_univ
   import shift_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld,
   input  logic [WIDTH-1:0]           d,
   input  logic                       en,
   input  logic [1:0]                 mode,
   input  logic                       sil,
   input  logic                       sir,
   output logic [WIDTH-1:0]           q,
   output logic                       so,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
);

   logic [WIDTH-1:0] q_next;
   logic             shift_edge;
   mode_t            mode_sel;

   assign mode_sel   = mode_t'(mode);
   assign shift_edge = en & ~ld;

   always_comb begin
      q_next = q;
      if (ld) begin
         q_next = d;
      end else if (en) begin
         unique case (mode_sel)
            SHL:     q_next = {q[WIDTH-2:0], sil};
            SHR:     q_next = {sir, q[WIDTH-1:1]};
            ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            ROR:     q_next = {q[0], q[WIDTH-1:1]};
            default: q_next = q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else begin
         q <= q_next;
      end
   end

   // so is the bit about to leave q, so instances chain so -> sil/sir.
   assign so = is_right(mode_sel) ? q[0] : q[WIDTH-1];

   shift_frame_cnt #(
      .WIDTH (WIDTH)
   ) u_frame_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (ld),
      .inc  (shift_edge),
      .cnt  (cnt),
      .done (done)
   );

endmodule
